rand_stream_src: RTL and testbench
==================================

# rand_stream_src

Multi-channel, rate-controlled pseudo-random stream source with valid/ready outputs. It generalises the single-channel random source into several things:
- parametrised channel count and word width;
- a runtime emission rate and a reloadable seed;
- a deterministic counting mode;
- packet framing via `last`;
- an accepted-word counter.

It feeds FIFOs, UART and stream sinks in benches and on-board self-tests.

## Interface
- `BITS`, 8, data word width per channel; legal 1..64.
- `CHANNELS`, 2, number of independent output streams; legal 1..8.
- `SEED`, 64'h1, LFSR value loaded at reset. A value of 0 is replaced by 64'h1.
- `TAPS`, 64'h8000000000001713, Galois LFSR feedback mask.
- `PKT_LEN`, 16, words per packet; 0 disables `last`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  permits LFSR stepping and new word launches.
- `mode`  in  1  0 = random data, 1 = counting data.
- `rate`  in  8  launch threshold; 0 = never launch, 8'hFF = launch whenever possible.
- `seed_load`  in  1  load `seed` into the LFSR this edge.
- `seed`  in  64  runtime seed; 0 is replaced by 64'h1.
- `valid`  out  CHANNELS  per-channel word valid.
- `ready`  in  CHANNELS  per-channel sink ready.
- `data`  out  CHANNELS*BITS  channel c occupies bits [c*BITS +: BITS].
- `last`  out  CHANNELS  final word of a packet.
- `count`  out  32  total accepted words, all channels, wraps mod 2^32.

## Operation
- **LFSR.** 64-bit state S. Next state is (S>>1) ^ (S[0] ? TAPS : 0).
  - S steps every edge with `en`=1, unless `seed_load` is high.
  - `seed_load` has priority over stepping and is honoured even when `en`=0.
  - S never holds 0.
- **Gate.** Channel c uses the gate byte g_c = S[8c+7:8c] of the current, pre-update S.
  - gate_c = (`rate`==8'hFF) | (g_c < `rate`).
- **Slot free.** slot_free_c = !valid[c] | ready[c]. An accept is valid[c] & ready[c].
- **Launch.** A word launches on channel c at an edge when slot_free_c & `en` & gate_c.
  - valid[c] is set to 1.
  - data_c is loaded with ror(S, 8c+8)[BITS-1:0] when `mode`=0, or with w_c when `mode`=1.
  - last[c] is loaded with (PKT_LEN!=0 && p_c==PKT_LEN-1).
  - w_c increments (BITS wide, wraps).
  - p_c increments and wraps to 0 after PKT_LEN-1.
- **Accept with no launch.** valid[c] drops to 0. data and last keep their old values, which are don't-care.
- **Hold.** While valid[c]=1 and ready[c]=0, data_c and last[c] are stable regardless of `en`, `mode`, `rate` or `seed_load`.
- **`en`=0.** No launches and the LFSR is frozen. Pending words stay valid until accepted.
- **`count`.** Adds popcount(valid & ready) each edge.
- **Channels.** Channels are fully independent. They share only S.
- **Reset state.**
  - S = SEED (nonzero-fixed).
  - valid=0, data=0, last=0, count=0.
  - w_c=0, p_c=0.

## Timing
- Reset takes priority over everything. A reset mid-packet discards pending words and restarts w_c and p_c at 0.
- First possible valid: the first edge after `rst` deasserts, i.e. cycle 1 when `rate`=8'hFF and `en`=1.
- Throughput: one word per channel per cycle when `ready`=1 and `rate`=8'hFF. Back-to-back accept and launch happen on the same edge with no bubble.
- `seed_load` at edge k:
  - words launched at edge k still use the old S;
  - words launched at edge k+1 use S=seed.
- `mode` and `rate` are sampled only at launch edges.

## Test plan
- **Counting, single channel.**
  - Setup: `mode`=1, `rate`=8'hFF, `ready`=1, `en`=1, CHANNELS=1, BITS=8, PKT_LEN=16.
  - Required: data 0,1,2,…,255,0 on consecutive cycles from cycle 1, with no gaps; last=1 exactly on data 15, 31, 47; `count`=300 after 300 valid cycles.
- **Backpressure.**
  - Setup: hold ready[0]=0 for 10 cycles after a launch.
  - Required: valid stays 1; data and last are unchanged every cycle; no word is lost or duplicated when ready returns.
  - Check: in counting mode, the next accepted word is the held value plus 1.
- **Rate gating.**
  - `rate`=0 for 1000 cycles: valid stays 0 and `count` stays 0.
  - `rate`=8'h80 with always-ready: accepted fraction is 0.45–0.55 over 10000 cycles.
- **Random data model match.**
  - Setup: `mode`=0, `rate`=8'hFF, SEED=64'h1, CHANNELS=2, BITS=8.
  - Required: every accepted data value equals the bench LFSR model `ror(S,8c+8)[7:0]` bit-exactly for 1000 words per channel.
- **Seed reload.**
  - `seed_load` with `seed`=0 produces the same following data stream as a reset with SEED=64'h1.
  - A load with `seed`=64'hDEADBEEF during backpressure leaves the held word unchanged.
- **Enable and reset mid-packet.**
  - `en`=0 for 5 cycles mid-packet: no launches; the pending word remains valid; the counting sequence resumes with no skipped values.
  - `rst` pulse on word 7 of a packet: valid=0 and count=0 on the next cycle; the next word is data 0, and last first occurs at word 15.

Source files
------------

// File: rtl/rand_stream_src.sv
// Multi-channel, rate-gated pseudo-random / counting stream source with valid/ready handshake.
// One 64-bit Galois LFSR is shared by all channels. It supplies each channel's gate byte and its random data.
module rand_stream_src #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned CHANNELS = 2,
  parameter logic [63:0] SEED     = 64'h1,
  parameter logic [63:0] TAPS     = 64'h8000000000001713,
  parameter int unsigned PKT_LEN  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mode,
  input  logic [7:0]               rate,
  input  logic                     seed_load,
  input  logic [63:0]              seed,
  output logic [CHANNELS-1:0]      valid,
  input  logic [CHANNELS-1:0]      ready,
  output logic [CHANNELS*BITS-1:0] data,
  output logic [CHANNELS-1:0]      last,
  output logic [31:0]              count
);

  localparam int unsigned PW      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned PKT_MAX = (PKT_LEN == 0) ? 0 : PKT_LEN - 1;

  // A zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [63:0] nonzero(input logic [63:0] x);
    return (x == 64'h0) ? 64'h1 : x;
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  localparam logic [63:0] SEED_NZ = (SEED == 64'h0) ? 64'h1 : SEED;

  logic [63:0] s;
  logic [63:0] s_step;
  logic [31:0] accepts;

  assign s_step = nonzero((s >> 1) ^ (s[0] ? TAPS : 64'h0));

  // A seed load takes priority over stepping and is honoured even when en is low.
  always_ff @(posedge clk) begin
    if (rst)            s <= SEED_NZ;
    else if (seed_load) s <= nonzero(seed);
    else if (en)        s <= s_step;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [63:0]     rot;
    logic            gate;
    logic            launch;
    logic            last_hit;
    logic            v_q;
    logic            l_q;
    logic [BITS-1:0] d_q;
    logic [BITS-1:0] word;
    logic [PW-1:0]   pkt;

    assign rot      = ror64(s, 8 * c + 8);
    assign gate     = (rate == 8'hFF) || (s[8*c +: 8] < rate);
    assign launch   = (!v_q || ready[c]) && en && gate;
    assign last_hit = (PKT_LEN != 0) && (pkt == PW'(PKT_MAX));

    // Data and last only change on a launch, so a stalled word holds steady.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q  <= 1'b0;
        l_q  <= 1'b0;
        d_q  <= '0;
        word <= '0;
        pkt  <= '0;
      end else if (launch) begin
        v_q  <= 1'b1;
        d_q  <= mode ? word : rot[BITS-1:0];
        l_q  <= last_hit;
        word <= word + BITS'(1);
        if (PKT_LEN <= 1 || pkt == PW'(PKT_MAX)) pkt <= '0;
        else                                     pkt <= pkt + PW'(1);
      end else if (ready[c]) begin
        v_q <= 1'b0;
      end
    end

    assign valid[c]              = v_q;
    assign last[c]               = l_q;
    assign data[c*BITS +: BITS]  = d_q;
  end

  always_comb begin
    accepts = 32'h0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      accepts = accepts + 32'(valid[i] & ready[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count <= 32'h0;
    else     count <= count + accepts;
  end

endmodule

// File: tb/tb_rand_stream_src.sv
// Scoreboard bench for rand_stream_src (2 channels x 8 bits, 16-word packets).
// A spec-level model predicts every launched word into per-channel queues, and each DUT accept pops one.
module tb_rand_stream_src;

  localparam int CH = 2;
  localparam int W  = 8;
  localparam int PL = 16;
  localparam logic [63:0] SEED_P = 64'h1;
  localparam logic [63:0] TAPS_P = 64'h8000000000001713;

  logic              clk;
  logic              rst, en, mode, seed_load;
  logic [7:0]        rate;
  logic [63:0]       seed;
  logic [CH-1:0]     valid, ready, last;
  logic [CH*W-1:0]   data;
  logic [31:0]       count;

  rand_stream_src #(.BITS(W), .CHANNELS(CH), .SEED(SEED_P), .TAPS(TAPS_P), .PKT_LEN(PL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rate(rate), .seed_load(seed_load),
    .seed(seed), .valid(valid), .ready(ready), .data(data), .last(last), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] d; logic l; } exp_t;

  exp_t        sb [CH][$];
  logic [63:0] ms;
  logic        mv [CH];
  logic [W-1:0] mw [CH];
  int          mp [CH];
  logic [31:0] mcount;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[(i + n) % 64];
    return r;
  endfunction

  function automatic logic [63:0] fix(input logic [63:0] x);
    return (x == 0) ? 64'h1 : x;
  endfunction

  task automatic model_reset();
    ms = fix(SEED_P);
    mcount = 0;
    for (int c = 0; c < CH; c++) begin
      mv[c] = 1'b0; mw[c] = '0; mp[c] = 0; sb[c].delete();
    end
  endtask

  // Check outputs before the edge, advance the model with the current inputs, then clock once.
  task automatic tick();
    logic [63:0] r;
    exp_t        e;
    logic        acc, go;
    for (int c = 0; c < CH; c++) begin
      chk("valid", 64'(valid[c]), 64'(mv[c]));
      if (valid[c] === 1'b1) begin
        if (sb[c].size() == 0) chk("sb_empty", 64'(sb[c].size()), 64'd1);
        else begin
          chk("data", 64'(data[c*W +: W]), 64'(sb[c][0].d));
          chk("last", 64'(last[c]), 64'(sb[c][0].l));
          if (ready[c]) void'(sb[c].pop_front());
        end
      end
    end
    chk("count", 64'(count), 64'(mcount));
    if (rst) model_reset();
    else begin
      for (int c = 0; c < CH; c++) begin
        acc = mv[c] & ready[c];
        mcount = mcount + 32'(acc);
        go = (!mv[c] || ready[c]) && en && (rate == 8'hFF || ms[8*c +: 8] < rate);
        if (go) begin
          r = ror(ms, 8 * c + 8);
          e.d = mode ? mw[c] : r[W-1:0];
          e.l = (mp[c] == PL - 1);
          sb[c].push_back(e);
          mv[c] = 1'b1;
          mw[c] = mw[c] + 1'b1;
          mp[c] = (mp[c] == PL - 1) ? 0 : mp[c] + 1;
        end else if (acc) mv[c] = 1'b0;
      end
      if (seed_load) ms = fix(seed);
      else if (en)   ms = (ms >> 1) ^ (ms[0] ? TAPS_P : 64'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [CH*W-1:0] cap [20];
  logic [W-1:0]    held;
  logic [31:0]     c0;

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b1; rate = 8'hFF; seed_load = 1'b0; seed = 64'h0;
    ready = '1;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst = 1'b0;

    // Counting mode, always ready: 0,1,2,... from cycle 1, with last on 15, 31, 47.
    for (int i = 0; i < 301; i++) begin
      tick();
      if (i == 0) begin
        chk("first_valid", 64'(valid), 64'h3);
        chk("first_data", 64'(data[W-1:0]), 64'd0);
      end
      if (i == 15) chk("last15", 64'({data[W-1:0], last[0]}), 64'({8'd15, 1'b1}));
      if (i == 256) chk("wrap0", 64'(data[W-1:0]), 64'd0);
    end
    chk("count_300", 64'(count), 64'd600);

    // Backpressure on ch0 for 10 cycles, with a seed reload in the middle of the stall.
    held = data[W-1:0];
    ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      seed_load = (i == 5); seed = 64'hDEADBEEF;
      tick();
    end
    seed_load = 1'b0;
    chk("bp_valid", 64'(valid[0]), 64'd1);
    chk("bp_held", 64'(data[W-1:0]), 64'(held));
    ready = 2'b11;
    tick();
    chk("bp_next", 64'(data[W-1:0]), 64'(held + 8'd1));

    // Enable low for 5 cycles: ch0 stalls with its word pending, and ch1 drains.
    for (int i = 0; i < 5; i++) tick();
    held = data[W-1:0];
    en = 1'b0; ready = 2'b10;
    for (int i = 0; i < 5; i++) tick();
    chk("en0_valid", 64'(valid), 64'h1);
    chk("en0_held", 64'(data[W-1:0]), 64'(held));
    en = 1'b1; ready = 2'b11;
    for (int i = 0; i < 10; i++) tick();

    // Reset on word 7 of a packet restarts the data and packet counters.
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst7", 64'(data[W-1:0]), 64'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    tick();
    chk("post_rst_d0", 64'(data[W-1:0]), 64'd0);
    for (int i = 0; i < 15; i++) begin
      if (i < 15) chk("no_early_last", 64'(last[0]), 64'd0);
      tick();
    end
    chk("post_rst_last15", 64'({data[W-1:0], last[0]}), 64'({8'd15, 1'b1}));

    // Rate 0: nothing launches.
    do_reset();
    rate = 8'h00; mode = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    chk("rate0_count", 64'(count), 64'd0);

    // Rate 0x80: about half of the cycles launch.
    rate = 8'h80;
    c0 = count;
    for (int i = 0; i < 10000; i++) tick();
    c0 = count - c0;
    chk("rate80_frac", 64'(c0 >= 32'd9000 && c0 <= 32'd11000), 64'd1);

    // Random data, 1000 words per channel, against the LFSR model.
    rate = 8'hFF;
    do_reset();
    for (int i = 0; i < 1001; i++) tick();

    // A seed load with 0 replays the stream that follows a reset with SEED=1.
    do_reset();
    for (int i = 0; i < 20; i++) begin tick(); cap[i] = data; end
    for (int i = 0; i < 5; i++) tick();
    seed = 64'h0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("seed0_replay", 64'(data), 64'(cap[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
